// File: rtl/run_pkg.sv
// Shared definitions for the singlecycle run controller and its watchdog.
// State encoding and the default watchdog limit live here so other blocks agree.
package run_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESET = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } run_state_t;

   localparam int unsigned WD_LIMIT_DEFAULT = 255;

endpackage : run_pkg

// File: rtl/run_watchdog.sv
// Saturating cycle counter with synchronous clear, count enable and a flag
// raised while the count equals LIMIT.
module run_watchdog #(
   parameter int          W     = 16,
   parameter int unsigned LIMIT = 255
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count,
   output logic         limit_hit
);

   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   // Holding at LIMIT keeps the count from ever wrapping.
   assign limit_hit = (count == LIMIT_V);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge CLK) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !limit_hit) begin
         count <= count + W'(1);
      end
   end

endmodule : run_watchdog

// File: rtl/run_sequencer.sv
// Run controller for the singlecycle core: parks the core in reset, loads the
// start PC, releases it, then watches the PC for completion or watchdog timeout.
module run_sequencer
   import run_pkg::*;
#(
   parameter int          RESET_CYCLES = 2,
   parameter int          WD_W         = 16,
   parameter int unsigned WD_LIMIT     = WD_LIMIT_DEFAULT
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            start,
   input  logic [63:0]     start_pc,
   input  logic [63:0]     end_pc,
   output logic            core_resetl,
   output logic [63:0]     core_startpc,
   input  logic [63:0]     core_currentpc,
   input  logic [63:0]     core_memtoreg,
   output logic            busy,
   output logic            done,
   output logic            timeout,
   output logic [63:0]     result,
   output logic [WD_W-1:0] cycles
);

   localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

   run_state_t      state;
   logic [RC_W-1:0] rst_cnt;
   logic [63:0]     end_q;
   logic            start_ok;
   logic            pc_reached;
   logic            wd_hit;

   assign start_ok   = start && ((state == IDLE) || (state == DONE));
   assign pc_reached = (core_currentpc >= end_q);

   run_watchdog #(
      .W     (WD_W),
      .LIMIT (WD_LIMIT)
   ) u_watchdog (
      .CLK       (CLK),
      .reset     (reset),
      .clear     (start_ok),
      .enable    ((state == RUN) && !pc_reached),
      .count     (cycles),
      .limit_hit (wd_hit)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state        <= IDLE;
         rst_cnt      <= '0;
         end_q        <= '0;
         core_resetl  <= 1'b0;
         core_startpc <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         result       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= RESET;
                  rst_cnt      <= RC_LOAD;
                  core_startpc <= start_pc;
                  end_q        <= end_pc;
                  core_resetl  <= 1'b0;
                  busy         <= 1'b1;
                  timeout      <= 1'b0;
                  result       <= '0;
               end
            end
            RESET: begin
               // Reset is held for RESET_CYCLES cycles counted from rst_cnt = RESET_CYCLES-1.
               if (rst_cnt == '0) begin
                  state       <= RUN;
                  core_resetl <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt - RC_W'(1);
               end
            end
            RUN: begin
               // Completion is checked first so it wins over a same-cycle limit hit.
               if (pc_reached) begin
                  result <= core_memtoreg;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else if (wd_hit) begin
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : run_sequencer

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a behavioural core stand-in whose PC
// steps by 4 per cycle once released (or spins at 0x8 in loop mode).
module tb_run_sequencer;

   localparam int RESET_CYCLES = 2;

   logic        CLK = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] start_pc;
   logic [63:0] end_pc;
   logic        core_resetl;
   logic [63:0] core_startpc;
   logic [63:0] core_currentpc;
   logic [63:0] core_memtoreg;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [63:0] result;
   logic [15:0] cycles;

   run_sequencer dut (
      .CLK            (CLK),
      .reset          (reset),
      .start          (start),
      .start_pc       (start_pc),
      .end_pc         (end_pc),
      .core_resetl    (core_resetl),
      .core_startpc   (core_startpc),
      .core_currentpc (core_currentpc),
      .core_memtoreg  (core_memtoreg),
      .busy           (busy),
      .done           (done),
      .timeout        (timeout),
      .result         (result),
      .cycles         (cycles)
   );

   always #5 CLK = ~CLK;

   // Core stand-in: PC reloads while held in reset, then advances one instruction per cycle.
   logic [63:0] pc = 64'h0;
   logic        loop_mode = 1'b0;
   logic [63:0] mem_pc = 64'h0;
   logic [63:0] mem_val = 64'h0;

   always @(posedge CLK) begin
      if (!core_resetl) pc <= core_startpc;
      else if (!(loop_mode && pc == 64'h8)) pc <= pc + 64'd4;
   end

   assign core_currentpc = pc;
   assign core_memtoreg  = (pc == mem_pc) ? mem_val : 64'hBAD0_BAD0_BAD0_BAD0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [63:0] spc;
      logic [63:0] epc;
      logic [63:0] mpc;
      logic [63:0] mval;
      bit          loop;
      logic [63:0] exp_result;
      int          exp_cycles;
      bit          exp_timeout;
   } vec_t;

   function automatic vec_t mk(input string name, input logic [63:0] spc, input logic [63:0] epc,
                               input logic [63:0] mval, input bit loop, input logic [63:0] exp_result,
                               input int exp_cycles, input bit exp_timeout);
      vec_t v;
      v.name = name; v.spc = spc; v.epc = epc; v.mpc = epc; v.mval = mval; v.loop = loop;
      v.exp_result = exp_result; v.exp_cycles = exp_cycles; v.exp_timeout = exp_timeout;
      return v;
   endfunction

   task automatic pulse_start(input logic [63:0] spc, input logic [63:0] epc);
      @(negedge CLK);
      start_pc = spc;
      end_pc   = epc;
      start    = 1'b1;
      @(negedge CLK);
      start    = 1'b0;
   endtask

   // Waits (bounded) for done or timeout; returns 1 if either was seen.
   task automatic wait_end(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK);
         if (done || timeout) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int low;
      bit seen;
      mem_pc    = v.mpc;
      mem_val   = v.mval;
      loop_mode = v.loop;
      pulse_start(v.spc, v.epc);
      check({v.name, ".busy_after_start"}, 64'(busy), 64'd1);
      check({v.name, ".startpc"}, core_startpc, v.spc);
      low = 0;
      while (busy && !core_resetl && low < 50) begin
         low++;
         @(negedge CLK);
      end
      check({v.name, ".reset_low_cycles"}, 64'(low), 64'(RESET_CYCLES));
      wait_end(seen);
      check({v.name, ".finished"}, 64'(seen), 64'd1);
      check({v.name, ".done"}, 64'(done), 64'(!v.exp_timeout));
      check({v.name, ".timeout"}, 64'(timeout), 64'(v.exp_timeout));
      check({v.name, ".busy_at_end"}, 64'(busy), 64'd0);
      check({v.name, ".result"}, result, v.exp_result);
      check({v.name, ".cycles"}, 64'(cycles), 64'(v.exp_cycles));
      @(negedge CLK);
      check({v.name, ".done_drop"}, 64'(done), 64'd0);
      check({v.name, ".timeout_held"}, 64'(timeout), 64'(v.exp_timeout));
      check({v.name, ".cycles_held"}, 64'(cycles), 64'(v.exp_cycles));
      check({v.name, ".result_held"}, result, v.exp_result);
   endtask

   vec_t vecs[7];

   initial begin
      bit seen;
      int n_done;
      vecs[0] = mk("prog1",    64'h0,   64'h30,  64'hF, 1'b0, 64'hF, 12, 1'b0);
      vecs[1] = mk("prog2",    64'h30,  64'h5C,  64'h1234_5678_9ABC_DEF0, 1'b0,
                   64'h1234_5678_9ABC_DEF0, 11, 1'b0);
      vecs[2] = mk("equal",    64'h40,  64'h40,  64'hA5A5, 1'b0, 64'hA5A5, 0, 1'b0);
      vecs[3] = mk("loop_wd",  64'h0,   64'h100, 64'h77, 1'b1, 64'h0, 255, 1'b1);
      vecs[4] = mk("past_end", 64'h80,  64'h40,  64'h1234, 1'b0, 64'h1234, 0, 1'b0);
      vecs[4].mpc = 64'h80;
      vecs[5] = mk("unsigned", 64'hFFFF_FFFF_FFFF_FFF0, 64'h8000_0000_0000_0000, 64'hCAFE, 1'b0,
                   64'hCAFE, 0, 1'b0);
      vecs[5].mpc = 64'hFFFF_FFFF_FFFF_FFF0;
      vecs[6] = mk("short",    64'h100, 64'h108, 64'h55, 1'b0, 64'h55, 2, 1'b0);

      reset = 1'b1; start = 1'b0; start_pc = '0; end_pc = '0;
      repeat (3) @(negedge CLK);
      check("rst.core_resetl", 64'(core_resetl), 64'd0);
      check("rst.core_startpc", core_startpc, 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.timeout", 64'(timeout), 64'd0);
      check("rst.result", result, 64'd0);
      check("rst.cycles", 64'(cycles), 64'd0);
      reset = 1'b0;
      @(negedge CLK);
      check("idle.core_resetl", 64'(core_resetl), 64'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // DONE keeps the core released so its PC stays observable.
      check("done_state.core_resetl", 64'(core_resetl), 64'd1);

      // start during RUN must be ignored: latched end_pc and start_pc stay put.
      mem_pc = 64'h30; mem_val = 64'h99; loop_mode = 1'b0;
      pulse_start(64'h0, 64'h30);
      repeat (5) @(negedge CLK);
      start_pc = 64'h200; end_pc = 64'h10; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("ign.busy", 64'(busy), 64'd1);
      check("ign.startpc", core_startpc, 64'h0);
      wait_end(seen);
      check("ign.finished", 64'(seen), 64'd1);
      check("ign.done", 64'(done), 64'd1);
      check("ign.result", result, 64'h99);
      check("ign.cycles", 64'(cycles), 64'd12);

      // reset mid-RUN aborts: core re-parked, nothing reported.
      mem_pc = 64'h100; mem_val = 64'h42;
      pulse_start(64'h0, 64'h100);
      repeat (6) @(negedge CLK);
      check("abort.in_run", 64'(core_resetl), 64'd1);
      reset = 1'b1;
      @(negedge CLK);
      check("abort.core_resetl", 64'(core_resetl), 64'd0);
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.done", 64'(done), 64'd0);
      check("abort.result", result, 64'd0);
      check("abort.cycles", 64'(cycles), 64'd0);
      check("abort.timeout", 64'(timeout), 64'd0);
      reset = 1'b0;
      n_done = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLK);
         if (done || timeout || busy || core_resetl) n_done++;
      end
      check("abort.quiet", 64'(n_done), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_run_sequencer
